wrr_router: RTL and testbench
=============================

# wrr_router

Parametrised weighted-round-robin arbiter and destination router for the transaction layer. It pops one word per cycle from `NUM_CH` input FIFOs using per-channel run-time weights, with an optional strict-priority mode. Each popped word is routed to one of `NUM_CH` output FIFOs according to its destination field. Output almost-full backpressure is honoured. It sits between the input VC FIFOs and the output FIFOs, and supersedes the fixed 4/3/2/1 pop-push referee.

## Interface
- `NUM_CH`, default 4: number of input FIFOs and of output FIFOs; power of two, 2..8.
- `DATA_W`, default 12: word width.
- `DEST_LSB`, default 8: LSB of the destination field, which is `data_in[DEST_LSB +: $clog2(NUM_CH)]`.
- `WEIGHT_W`, default 4: width of each channel weight.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `active`, in, 1: arbitration enable (controller in ACTIVE or IDLE state); when low, no new pops.
- `mode`, in, 1: 0 = WRR, 1 = strict priority (lowest index wins).
- `weights`, in, `NUM_CH*WEIGHT_W`: channel i weight at `[i*WEIGHT_W +: WEIGHT_W]`; 0 means the channel is never granted in WRR.
- `empty`, in, `NUM_CH`: input FIFO empty flags.
- `almost_full`, in, `NUM_CH`: output FIFO almost-full flags.
- `data_in`, in, `DATA_W`: read data of the currently popped input FIFO, valid the cycle after `pop`.
- `pop`, out, `NUM_CH`: one-hot or zero, registered.
- `push`, out, `NUM_CH`: one-hot or zero, registered.
- `data_out`, out, `DATA_W`: registered copy of the routed word.
- `grant_idx`, out, `$clog2(NUM_CH)`: channel currently holding the grant.

## Operation
- Pop eligibility: `active & ~|almost_full & ~empty[grant]`.
- WRR state is a grant pointer plus a credit counter (`WEIGHT_W` bits).
- WRR grant:
  - On each pop, credit decrements.
  - When credit reaches 0 after a pop, or `empty[grant]` is set, or `weights[grant]==0`, the grant moves to the next index in circular order (wrap `NUM_CH-1`→0) whose input is non-empty and whose weight is non-zero. Credit loads from that channel's weight.
  - The move happens in the same cycle as the search, so a pop may issue on the newly granted channel in that cycle.
  - If no channel is eligible, the pointer holds and no pop is issued.
- Strict mode: grant is the lowest index with `~empty`; weights and credit are ignored. Credit reloads on return to WRR.
- Weights are sampled only at credit load. A mid-run change takes effect at the next load.
- Routing pipeline:
  - Stage 1: a `pop` issued in cycle t sets an in-flight flag for t+1.
  - Stage 2: in t+1 the block samples `data_in` and the destination field. In t+2 it drives `push[dest]=1` and `data_out`.
  - Stage 2 always completes even if `almost_full` rises or `active` drops. Output FIFOs guarantee almost-full margin ≥2.
- Reset clears `pop`, `push`, `data_out`, the in-flight flag, grant pointer (0) and credit (0). On the first eligible cycle after reset, credit loads from `weights[0]`.

## Timing
- Throughput: one word per cycle sustained. Pop to push latency is exactly 2 cycles.
- `almost_full` seen high in cycle t means `pop` is 0 in t+1. At most 2 pushes occur after the flag rises.
- Simultaneous credit exhaustion and `empty` on the same channel gives a single advance, not a double skip.
- Reset asserted mid-transfer drops in-flight words; `push` is 0 in the cycle after reset.
- All outputs change only on `clk` rising edges. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `tl_pkg`: the `DEST_LSB` default, destination-width function, and the `MODE_WRR` / `MODE_PRIO` constants.
- Sub-module `rr_next_sel`: combinational circular next-eligible search from the pointer, returning index and found flag. It is reused by the output scheduler.
- Top level holds the pointer and credit registers, the pop register, the 2-stage routing pipe, and the one-hot push decode.

## Test plan
- WRR, weights {4,3,2,1}, all inputs non-empty, no backpressure, 20 cycles → pop sequence 0,0,0,0,1,1,1,2,2,3 repeating; `push` follows 2 cycles later, one per cycle.
- Weights {2,0,2,1}, all non-empty → channel 1 is never popped; sequence 0,0,2,2,3.
- Channel 1 empty after one word with weight 3 → one pop of 1, grant moves to 2 in the next cycle with no idle cycle.
- `almost_full[2]` raised for 5 cycles during streaming → `pop` is 0 from the next cycle, exactly 2 in-flight pushes complete, popping resumes one cycle after the flag falls.
- Strict mode with inputs 1 and 3 non-empty → only channel 1 is popped until it is empty, then channel 3. Words with destination field 2 → `push`=4'b0100 and `data_out` equals the word.
- Reset asserted during streaming → next cycle `pop`/`push`=0 and `grant_idx`=0; the first pop after release is on channel 0 with a fresh credit.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions: default destination field position,
// destination/index width helper and the arbitration mode encodings.
package tl_pkg;

    localparam int DEST_LSB_DEF = 8;

    localparam logic MODE_WRR  = 1'b0;
    localparam logic MODE_PRIO = 1'b1;

    // Width of a channel index / destination field for n channels.
    function automatic int dest_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Circular next-eligible search: first set bit of req_i at or after start_i,
// wrapping N-1 -> 0. Ports: req_i (eligible mask), start_i, idx_o, found_o.
module rr_next_sel
    import tl_pkg::*;
#(
    parameter int  N  = 4,
    localparam int IW = dest_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] cand;

    // Walk backwards so the candidate closest to start_i is written last.
    // N is a power of two, so the IW-bit add wraps the index for free.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = start_i + IW'(k);
            if (req_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wrr_router.sv
// Weighted-round-robin / strict-priority arbiter popping NUM_CH input FIFOs
// and routing each word to the output FIFO named by its destination field.
// Ports: clk, reset (sync, active-high), active, mode, weights, empty,
// almost_full, data_in (valid the cycle after pop) -> pop, push, data_out,
// grant_idx. All outputs are registered.
module wrr_router
    import tl_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  DATA_W   = 12,
    parameter int  DEST_LSB = DEST_LSB_DEF,
    parameter int  WEIGHT_W = 4,
    localparam int IW       = dest_w(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       active,
    input  logic                       mode,
    input  logic [NUM_CH*WEIGHT_W-1:0] weights,
    input  logic [NUM_CH-1:0]          empty,
    input  logic [NUM_CH-1:0]          almost_full,
    input  logic [DATA_W-1:0]          data_in,
    output logic [NUM_CH-1:0]          pop,
    output logic [NUM_CH-1:0]          push,
    output logic [DATA_W-1:0]          data_out,
    output logic [IW-1:0]              grant_idx
);

    logic [IW-1:0]       ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic                start_q, start_d;
    logic [NUM_CH-1:0]   pop_q, pop_d;
    logic                inflight_q;
    logic [NUM_CH-1:0]   push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [NUM_CH-1:0]   wnz;
    logic [NUM_CH-1:0]   wrr_req;
    logic [IW-1:0]       sel_start;
    logic [IW-1:0]       s_idx, p_idx;
    logic                s_found, p_found;
    logic [WEIGHT_W-1:0] w_sel;
    logic                can_pop;
    logic                keep;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            wnz[i] = |weights[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    assign wrr_req = ~empty & wnz;

    // start_q marks a pointer whose credit was never loaded (after reset or
    // strict mode): search includes the pointer itself. Otherwise the search
    // begins one past it, so the current channel is considered last.
    assign sel_start = start_q ? ptr_q : ptr_q + IW'(1);

    rr_next_sel #(.N(NUM_CH)) u_wrr_sel (
        .req_i   (wrr_req),
        .start_i (sel_start),
        .idx_o   (s_idx),
        .found_o (s_found)
    );

    rr_next_sel #(.N(NUM_CH)) u_prio_sel (
        .req_i   (~empty),
        .start_i ('0),
        .idx_o   (p_idx),
        .found_o (p_found)
    );

    assign w_sel   = weights[int'(s_idx)*WEIGHT_W +: WEIGHT_W];
    assign can_pop = active & ~(|almost_full);
    assign keep    = ~start_q & (credit_q != '0)
                   & ~empty[ptr_q] & wnz[ptr_q];

    always_comb begin
        ptr_d    = ptr_q;
        credit_d = credit_q;
        start_d  = start_q;
        pop_d    = '0;
        if (mode == MODE_PRIO) begin
            start_d = 1'b1;
            if (can_pop && p_found) begin
                ptr_d        = p_idx;
                pop_d[p_idx] = 1'b1;
            end
        end else if (can_pop) begin
            if (keep) begin
                credit_d     = credit_q - WEIGHT_W'(1);
                pop_d[ptr_q] = 1'b1;
            end else if (s_found) begin
                // Move, load and pop in the same cycle.
                ptr_d        = s_idx;
                credit_d     = w_sel - WEIGHT_W'(1);
                start_d      = 1'b0;
                pop_d[s_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        push_d = '0;
        data_d = data_q;
        if (inflight_q) begin
            push_d[data_in[DEST_LSB +: IW]] = 1'b1;
            data_d                          = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            credit_q   <= '0;
            start_q    <= 1'b1;
            pop_q      <= '0;
            inflight_q <= 1'b0;
            push_q     <= '0;
            data_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            credit_q   <= credit_d;
            start_q    <= start_d;
            pop_q      <= pop_d;
            inflight_q <= |pop_q;
            push_q     <= push_d;
            data_q     <= data_d;
        end
    end

    assign pop       = pop_q;
    assign push      = push_q;
    assign data_out  = data_q;
    assign grant_idx = ptr_q;

endmodule

// File: tb/tb_wrr_router.sv
// Directed bench for wrr_router: FIFO model plus push scoreboard keyed on
// pop order, with pop-sequence checks for each arbitration scenario.
module tb_wrr_router;
    import tl_pkg::*;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int WW = 4;
    localparam int IW = 2;
    localparam int DL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          active;
    logic          mode;
    logic [N*WW-1:0] weights;
    logic [N-1:0]  empty;
    logic [N-1:0]  almost_full;
    logic [DW-1:0] data_in = '0;
    logic [N-1:0]  pop;
    logic [N-1:0]  push;
    logic [DW-1:0] data_out;
    logic [IW-1:0] grant_idx;

    typedef struct {
        logic [DW-1:0] w;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    int            loaded[N];
    int            popped[N];
    int            dest_force;
    int            cyc = 0;
    int            pop_at[2048];
    bit            push_at[2048];
    logic [DW-1:0] pend_w;
    bit            have_pend = 1'b0;
    int            passed = 0;
    int            total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_empty
        assign empty[g] = (loaded[g] <= popped[g]);
    end

    wrr_router dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .mode        (mode),
        .weights     (weights),
        .empty       (empty),
        .almost_full (almost_full),
        .data_in     (data_in),
        .pop         (pop),
        .push        (push),
        .data_out    (data_out),
        .grant_idx   (grant_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mkword(input int ch, input int s,
                                             input int df);
        logic [1:0] d;
        d = (df >= 0) ? 2'(df) : 2'(ch + s);
        return {2'(ch), d, 8'(s)};
    endfunction

    function automatic logic [N*WW-1:0] wv(input int a, input int b,
                                          input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    // Input FIFO model and push scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] oh;
        exp_t         e;
        int           ch;
        cyc++;
        if (have_pend) data_in = pend_w;
        have_pend    = 1'b0;
        pop_at[cyc]  = -1;
        push_at[cyc] = 1'b0;
        if (cyc > 2) begin
            chk("pop_onehot0", 64'($onehot0(pop)), 64'd1);
            chk("push_onehot0", 64'($onehot0(push)), 64'd1);
            if (push !== '0) begin
                push_at[cyc] = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("push_unexpected", 64'(push), 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e.w[DL +: IW]] = 1'b1;
                    chk("push_dest", 64'(push), 64'(oh));
                    chk("data_out", 64'(data_out), 64'(e.w));
                    chk("push_latency", 64'(cyc), 64'(e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e.w[DL +: IW]] = 1'b1;
                chk("push_missing", 64'(push), 64'(oh));
            end
        end
        if (reset) exp_q.delete();
        if (pop !== '0 && $onehot(pop)) begin
            ch = 0;
            for (int i = 0; i < N; i++) if (pop[i]) ch = i;
            chk("pop_nonempty", 64'(loaded[ch] > popped[ch]), 64'd1);
            pend_w = mkword(ch, popped[ch], dest_force);
            popped[ch]++;
            pop_at[cyc] = ch;
            if (!reset) begin
                exp_q.push_back('{pend_w, cyc + 2});
                have_pend = 1'b1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic set_avail(input int a0, input int a1,
                             input int a2, input int a3);
        loaded[0] = popped[0] + a0;
        loaded[1] = popped[1] + a1;
        loaded[2] = popped[2] + a2;
        loaded[3] = popped[3] + a3;
    endtask

    task automatic check_seq(input string tag, input int from,
                             input int exp[$]);
        int c;
        c = -1;
        for (int k = from; k < from + 20; k++)
            if (c < 0 && pop_at[k] >= 0) c = k;
        if (c < 0) chk({tag, "_start"}, 64'(c), 64'(from));
        else
            for (int k = 0; k < exp.size(); k++)
                chk(tag, 64'(pop_at[c + k]), 64'(exp[k]));
    endtask

    initial begin
        int t0;
        int tf;
        int tr;
        int n;
        int q[$];
        for (int i = 0; i < N; i++) begin
            loaded[i] = 0;
            popped[i] = 0;
        end
        reset       = 1'b1;
        active      = 1'b0;
        mode        = MODE_WRR;
        weights     = '0;
        almost_full = '0;
        dest_force  = -1;
        cycles(3);
        chk("reset_pop", 64'(pop), 64'd0);
        chk("reset_push", 64'(push), 64'd0);
        chk("reset_data", 64'(data_out), 64'd0);
        chk("reset_grant", 64'(grant_idx), 64'd0);
        reset = 1'b0;

        weights = wv(4, 3, 2, 1);
        set_avail(500, 500, 500, 500);
        t0 = cyc;
        active = 1'b1;
        cycles(24);
        active = 1'b0;
        cycles(4);
        q = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3,
              0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
        check_seq("wrr_4321", t0, q);
        chk("drain_4321", 64'(exp_q.size()), 64'd0);

        do_reset();
        weights = wv(2, 0, 2, 1);
        t0 = cyc;
        active = 1'b1;
        cycles(18);
        active = 1'b0;
        cycles(4);
        q = '{0, 0, 2, 2, 3, 0, 0, 2, 2, 3, 0, 0, 2, 2, 3};
        check_seq("wrr_zero_w", t0, q);

        do_reset();
        weights = wv(4, 3, 2, 1);
        set_avail(0, 1, 100, 100);
        t0 = cyc;
        active = 1'b1;
        cycles(12);
        active = 1'b0;
        cycles(4);
        q = '{1, 2, 2, 3, 2, 2, 3};
        check_seq("empty_adv", t0, q);

        do_reset();
        weights = wv(4, 3, 2, 1);
        set_avail(500, 500, 500, 500);
        active = 1'b1;
        cycles(6);
        tf = cyc + 1;
        almost_full = 4'b0100;
        cycles(5);
        almost_full = '0;
        cycles(6);
        active = 1'b0;
        cycles(4);
        chk("af_pop_at_rise", 64'(pop_at[tf] >= 0), 64'd1);
        for (int k = 1; k <= 5; k++)
            chk("af_pop_stall", 64'(pop_at[tf + k]), 64'(-1));
        chk("af_resume", 64'(pop_at[tf + 6] >= 0), 64'd1);
        n = 0;
        for (int k = 1; k <= 5; k++) n += int'(push_at[tf + k]);
        chk("af_push_count", 64'(n), 64'd2);
        chk("af_push_t1", 64'(push_at[tf + 1]), 64'd1);
        chk("af_push_t2", 64'(push_at[tf + 2]), 64'd1);

        do_reset();
        mode = MODE_PRIO;
        weights = '0;
        dest_force = 2;
        set_avail(0, 3, 0, 4);
        t0 = cyc;
        active = 1'b1;
        cycles(12);
        active = 1'b0;
        cycles(4);
        q = '{1, 1, 1, 3, 3, 3, 3, -1, -1};
        check_seq("prio_seq", t0, q);
        n = 0;
        for (int k = t0; k <= cyc; k++) n += int'(push_at[k]);
        chk("prio_push_count", 64'(n), 64'd7);
        mode = MODE_WRR;
        dest_force = -1;

        do_reset();
        weights = wv(4, 3, 2, 1);
        set_avail(500, 500, 500, 500);
        active = 1'b1;
        cycles(6);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        tr = cyc + 1;
        chk("rst_mid_pop", 64'(pop), 64'd0);
        chk("rst_mid_push", 64'(push), 64'd0);
        chk("rst_mid_grant", 64'(grant_idx), 64'd0);
        cycles(10);
        active = 1'b0;
        cycles(4);
        chk("rst_first_pop", 64'(pop_at[tr + 1]), 64'd0);
        q = '{0, 0, 0, 0, 1, 1, 1};
        check_seq("rst_seq", tr, q);
        chk("drain_final", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
